// File: rtl/rx_cmd_pkg.sv
// Shared types and defaults for the UART three-byte command assembler.
package rx_cmd_pkg;

  localparam int DBIT_DEFAULT          = 8;
  // 16x oversampling, 11 bit times per frame, 4 frames of slack
  localparam int TIMEOUT_TICKS_DEFAULT = 16 * 11 * 4;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/tick_timeout_counter.sv
// Saturating inter-byte gap counter; expired flags the tick that completes TICKS counts.
module tick_timeout_counter #(
  parameter int TICKS = 704
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Stops at LAST instead of wrapping; the owner clears it on expiry
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && tick && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable & tick & (cnt_q == LAST);

endmodule

// File: rtl/rx_cmd_assembler.sv
// Collects three UART bytes (op_a, op_b, opcode) into a held command with valid/ready.
// Optional gap timeout enabled by defining RX_CMD_TIMEOUT_EN.
module rx_cmd_assembler
  import rx_cmd_pkg::*;
#(
  parameter int DBIT          = DBIT_DEFAULT,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DBIT-1:0] din,
  input  logic            rx_done_tick,
  input  logic            s_tick,
  output logic [DBIT-1:0] op_a,
  output logic [DBIT-1:0] op_b,
  output logic [DBIT-1:0] opcode,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic            overrun,
  output logic            timeout_err
);

  state_e            state_q, state_d;
  logic [DBIT-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, opcode_q, opcode_d;
  logic              overrun_q, overrun_d, timeout_q, timeout_d;
  logic              expired;

`ifdef RX_CMD_TIMEOUT_EN
  logic tmr_clear, tmr_enable;

  assign tmr_enable = (state_q == WAIT_B) || (state_q == WAIT_OP);
  assign tmr_clear  = rx_done_tick || ((state_d == WAIT_A) && (state_q != WAIT_A));

  tick_timeout_counter #(
    .TICKS   (TIMEOUT_TICKS)
  ) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .tick    (s_tick),
    .expired (expired)
  );
`else
  logic unused_inputs;

  assign expired       = 1'b0;
  assign unused_inputs = s_tick | (TIMEOUT_TICKS < 2);
`endif

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    opcode_d  = opcode_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (rx_done_tick) begin
          op_a_d  = din;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_tick) begin
          op_b_d  = din;
          state_d = WAIT_OP;
        end else if (expired) begin
          state_d   = WAIT_A;
          timeout_d = 1'b1;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          opcode_d = din;
          state_d  = HOLD;
        end else if (expired) begin
          state_d   = WAIT_A;
          timeout_d = 1'b1;
        end
      end
      HOLD: begin
        // A byte arriving with the handshake starts the next command directly
        if (cmd_ready) begin
          if (rx_done_tick) begin
            op_a_d  = din;
            state_d = WAIT_B;
          end else begin
            state_d = WAIT_A;
          end
        end else if (rx_done_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_A;
      op_a_q    <= '0;
      op_b_q    <= '0;
      opcode_q  <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      opcode_q  <= opcode_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign opcode      = opcode_q;
  assign cmd_valid   = (state_q == HOLD);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: doc/rx_cmd_assembler.md
RX_CMD_ASSEMBLER -- requirements
Module: rx_cmd_assembler

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, giving the received byte width.
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 16*11*4 = 704, giving the maximum inter-byte gap in s_tick pulses.
REQ-003 Port clk  input  1  clock; all logic on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port din  input  DBIT  byte from the upstream UART receiver, valid only when rx_done_tick=1.
REQ-006 Port rx_done_tick  input  1  one-clk pulse marking a new byte on din.
REQ-007 Port s_tick  input  1  oversampling tick from the baud-rate generator; time base for the timeout.
REQ-008 Port op_a  output  DBIT  first byte of the assembled command.
REQ-009 Port op_b  output  DBIT  second byte of the assembled command.
REQ-010 Port opcode  output  DBIT  third byte of the assembled command.
REQ-011 Port cmd_valid  output  1  high while a complete command is presented.
REQ-012 Port cmd_ready  input  1  downstream accepts the command when high with cmd_valid.
REQ-013 Port overrun  output  1  one-clk pulse: a byte was dropped.
REQ-014 Port timeout_err  output  1  one-clk pulse: partial command discarded on gap timeout.

Function
REQ-015 The FSM SHALL have states WAIT_A, WAIT_B, WAIT_OP and HOLD.
REQ-016 In WAIT_A, on rx_done_tick, din SHALL be registered into op_a and the state SHALL become WAIT_B on the next clk.
REQ-017 In WAIT_B, on rx_done_tick, din SHALL be registered into op_b and the state SHALL become WAIT_OP.
REQ-018 In WAIT_OP, on rx_done_tick, din SHALL be registered into opcode and the state SHALL become HOLD.
REQ-019 cmd_valid SHALL be 1 exactly while in HOLD, starting the clk after the third byte is received (latency 1 clk).
REQ-020 op_a, op_b and opcode SHALL remain stable while cmd_valid=1.
REQ-021 In HOLD, cmd_valid=1 with cmd_ready=1 SHALL complete the handshake, and the state SHALL become WAIT_A.
REQ-022 In HOLD with cmd_ready=0, rx_done_tick SHALL drop the byte and pulse overrun for 1 clk, and the state SHALL remain HOLD.
REQ-023 In HOLD, rx_done_tick together with cmd_ready=1 SHALL complete the handshake, capture din into op_a and move to WAIT_B, with no overrun.
REQ-024 The gap counter SHALL be cleared on every rx_done_tick and on entry to WAIT_A.
REQ-025 The gap counter SHALL increment on each s_tick while in WAIT_B or WAIT_OP, and it SHALL hold in WAIT_A and HOLD.
REQ-026 When the gap counter equals TIMEOUT_TICKS-1 and s_tick=1 with no rx_done_tick, the state SHALL become WAIT_A and timeout_err SHALL pulse for 1 clk.
REQ-027 If rx_done_tick and a timeout occur in the same clk, the byte SHALL win, and no timeout_err SHALL be raised.
REQ-028 The gap counter SHALL be $clog2(TIMEOUT_TICKS) bits wide and SHALL never wrap.
REQ-029 cmd_ready SHALL be ignored outside HOLD.

Reset
REQ-030 Reset SHALL force the state to WAIT_A, op_a/op_b/opcode to 0, cmd_valid, overrun and timeout_err to 0, and the gap counter to 0.
REQ-031 Reset asserted mid-command or in HOLD SHALL discard the partial or pending command, and no pulses SHALL be generated.
REQ-032 Reset SHALL take priority over rx_done_tick and cmd_ready in the same clk.

Configuration
REQ-033 Macro RX_CMD_TIMEOUT_EN defined: the gap counter and timeout_err SHALL be implemented per REQ-024..REQ-028.
REQ-034 Macro RX_CMD_TIMEOUT_EN undefined: no gap counter SHALL exist, timeout_err SHALL be tied to 0, s_tick SHALL be unused, and a partial command SHALL wait indefinitely.

Structure
REQ-035 A shared package rx_cmd_pkg SHALL hold the state enum (WAIT_A, WAIT_B, WAIT_OP, HOLD), the default DBIT and the default TIMEOUT_TICKS constant.
REQ-036 The gap counter SHALL be a sub-module tick_timeout_counter (inputs clk, reset, clear, enable, tick; output expired), instantiated only under RX_CMD_TIMEOUT_EN.

Verification
REQ-037 Scenario: bytes 0x05, 0x03, 0x20 with cmd_ready=1 -> cmd_valid for 1 clk with op_a=0x05, op_b=0x03, opcode=0x20, then WAIT_A.
REQ-038 Scenario: full command with cmd_ready=0, then 4th byte 0x77 -> overrun pulses once, outputs unchanged; cmd_ready=1 later -> handshake, 0x77 not captured.
REQ-039 Scenario: in HOLD, rx_done_tick with din=0x11 and cmd_ready=1 in the same clk -> handshake completes, op_a=0x11, state WAIT_B, overrun=0.
REQ-040 Scenario: byte 0x05, then 704 s_ticks with no byte (macro defined) -> timeout_err pulses once and the next byte 0x09 lands in op_a.
REQ-041 Scenario: rx_done_tick coincident with the 704th s_tick -> byte accepted, timeout_err=0.
REQ-042 Scenario: reset asserted in WAIT_OP -> all outputs 0 next clk, no pulses; the following three bytes form a fresh command.
